microarchtrace_unpacker: RTL and testbench
==========================================

MICROARCHTRACE_UNPACKER -- requirements
Module: microarchtrace_unpacker

Interface
REQ-001 Parameter TIMEOUT, default 64: max idle cycles allowed between words of one packet, range 2..65535.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 s_valid  input  1  trace word present on s_data.
REQ-005 s_ready  output  1  unpacker accepts the word; a transfer occurs when s_valid && s_ready.
REQ-006 s_data  input  32  trace word (header, pc or insn).
REQ-007 if_valid / if_pc  output  1/32  fetch event pulse and pc.
REQ-008 de_valid / de_pc / de_insn  output  1/32/32  decode event pulse, pc and instruction.
REQ-009 ex_valid / ex_pc  output  1/32  execute event pulse and pc.
REQ-010 wb_valid / wb_pc  output  1/32  writeback event pulse and pc.
REQ-011 pkt_err  output  1  one-cycle pulse on a malformed or aborted packet.
REQ-012 seq_err  output  1  one-cycle pulse on a sequence gap.
REQ-013 evt_cnt  output  32  count of events emitted.

Function
REQ-014 Header word: [31:28] = 4'hA magic; [15:8] = seq; [3:0] = type, where 1=IF, 2=DE, 3=EX, 4=WB; all other bits are ignored.
REQ-015 Packet layout: IF/EX/WB = header, pc (2 words); DE = header, pc, insn (3 words).
REQ-016 FSM states: HDR, PC, INSN. HDR->PC on a valid header; PC->HDR on pc accepted (non-DE); PC->INSN on pc accepted (DE); INSN->HDR on insn accepted.
REQ-017 In HDR, a word with bad magic or type outside 1..4 is consumed and dropped; pkt_err pulses the next cycle; state stays HDR.
REQ-018 s_ready = 1 in every state except during the reset cycle; the unpacker never stalls the stream.
REQ-019 Emit latency: exactly one <stage>_valid pulses in the cycle after the final word of a packet is accepted; payload outputs are registered and hold until the next emit.
REQ-020 Only one <stage>_valid is high in any cycle.
REQ-021 Back-to-back: a header accepted in the same cycle an event pulses is processed normally.
REQ-022 evt_cnt increments by 1 on each emitted event and wraps 32'hFFFFFFFF -> 0.
REQ-023 Timeout: an idle counter runs while in PC or INSN and clears on each accepted word.
REQ-024 When the idle counter reaches TIMEOUT, the partial packet is discarded, pkt_err pulses, the state returns to HDR, and no event is emitted.
REQ-025 When pkt_err and seq_err are raised by the same word, both pulse in the same cycle.

Reset
REQ-026 On rst: state = HDR; all *_valid, pkt_err and seq_err = 0; all pc/insn outputs = 0; evt_cnt = 0; idle counter = 0; expected seq = 0; s_ready = 0.
REQ-027 rst asserted mid-packet discards the packet without emitting an event or pkt_err.

Configuration
REQ-028 Macro MICROARCHTRACE_UNPACK_SEQ_EN controls sequence checking.
REQ-029 Defined: each valid header's seq is compared with the expected value; on mismatch, seq_err pulses the cycle after the header and the packet is still decoded.
REQ-030 Defined: after every valid header, expected seq = header seq + 1 (mod 256).
REQ-031 Undefined: header bits [15:8] are ignored and seq_err is tied to 0.

Verification
REQ-032 Reset, then words A0000001, 00001000 -> if_valid pulses 1 cycle after the 2nd word with if_pc=00001000; evt_cnt=1.
REQ-033 Words A0000102, 00002000, 00B50513 -> de_valid pulse with de_pc=00002000, de_insn=00B50513; no other valid asserted.
REQ-034 Words 50000003, then 12345678 -> pkt_err pulses after each word, since both fail the header check in HDR; no event; evt_cnt unchanged.
REQ-035 Header A0000004, then s_valid low for 64 cycles -> pkt_err after the 64th idle cycle; a following complete WB packet emits wb_valid normally.
REQ-036 SEQ_EN defined, headers with seq 0, 1, 3 -> seq_err pulses once, after seq 3; all three events are emitted. Same stimulus with SEQ_EN undefined -> seq_err stays 0.
REQ-037 Preload evt_cnt to FFFFFFFF via 2^32 events or a forced value, then send one EX packet -> evt_cnt = 0 and ex_valid pulses.

Source files
------------

// File: rtl/microarchtrace_unpacker.sv
// Reassembles header/pc/insn trace words into per-stage pipeline events.
// Optional sequence-number checking is enabled by defining MICROARCHTRACE_UNPACK_SEQ_EN.
module microarchtrace_unpacker #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic        de_valid,
  output logic [31:0] de_pc,
  output logic [31:0] de_insn,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic        wb_valid,
  output logic [31:0] wb_pc,
  output logic        pkt_err,
  output logic        seq_err,
  output logic [31:0] evt_cnt
);

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    PC   = 2'd1,
    INSN = 2'd2
  } state_t;

  localparam logic [3:0]  MAGIC      = 4'hA;
  localparam logic [3:0]  T_IF       = 4'd1;
  localparam logic [3:0]  T_DE       = 4'd2;
  localparam logic [3:0]  T_EX       = 4'd3;
  localparam logic [3:0]  T_WB       = 4'd4;
  localparam logic [15:0] IDLE_LIMIT = 16'(TIMEOUT - 1);

  state_t      state, state_next;
  logic [3:0]  kind, kind_next;
  logic [31:0] pc_hold, pc_hold_next;
  logic [15:0] idle, idle_next;
  logic        xfer;
  logic        emit_if, emit_de, emit_ex, emit_wb, emit_any;
  logic [31:0] emit_pc, emit_insn;
  logic        abort;
  logic        seq_mis;

  function automatic logic hdr_ok(input logic [31:0] w);
    hdr_ok = (w[31:28] == MAGIC) && (w[3:0] >= T_IF) && (w[3:0] <= T_WB);
  endfunction

  // Never back-pressure the stream; only the reset cycle refuses a word.
  assign s_ready  = ~rst;
  assign xfer     = s_valid & s_ready;
  assign emit_any = emit_if | emit_de | emit_ex | emit_wb;

`ifdef MICROARCHTRACE_UNPACK_SEQ_EN
  logic [7:0] exp_seq;

  always_comb begin
    seq_mis = 1'b0;
    if ((state == HDR) && xfer && hdr_ok(s_data)) begin
      seq_mis = (s_data[15:8] != exp_seq);
    end else begin
      seq_mis = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_seq <= 8'd0;
    end else if ((state == HDR) && xfer && hdr_ok(s_data)) begin
      exp_seq <= s_data[15:8] + 8'd1;
    end
  end
`else
  assign seq_mis = 1'b0;
`endif

  always_comb begin
    state_next   = state;
    kind_next    = kind;
    pc_hold_next = pc_hold;
    idle_next    = idle;
    emit_if      = 1'b0;
    emit_de      = 1'b0;
    emit_ex      = 1'b0;
    emit_wb      = 1'b0;
    emit_pc      = s_data;
    emit_insn    = s_data;
    abort        = 1'b0;
    case (state)
      HDR: begin
        idle_next = 16'd0;
        if (xfer) begin
          if (hdr_ok(s_data)) begin
            kind_next  = s_data[3:0];
            state_next = PC;
          end else begin
            abort = 1'b1;
          end
        end else begin
          state_next = HDR;
        end
      end
      PC: begin
        if (xfer) begin
          idle_next    = 16'd0;
          pc_hold_next = s_data;
          if (kind == T_DE) begin
            state_next = INSN;
          end else begin
            state_next = HDR;
            case (kind)
              T_IF:    emit_if = 1'b1;
              T_EX:    emit_ex = 1'b1;
              T_WB:    emit_wb = 1'b1;
              default: abort   = 1'b1;
            endcase
          end
        end else if (idle == IDLE_LIMIT) begin
          // Partial packet went stale: drop it without an event.
          idle_next  = 16'd0;
          state_next = HDR;
          abort      = 1'b1;
        end else begin
          idle_next = idle + 16'd1;
        end
      end
      INSN: begin
        if (xfer) begin
          idle_next  = 16'd0;
          emit_de    = 1'b1;
          emit_pc    = pc_hold;
          emit_insn  = s_data;
          state_next = HDR;
        end else if (idle == IDLE_LIMIT) begin
          idle_next  = 16'd0;
          state_next = HDR;
          abort      = 1'b1;
        end else begin
          idle_next = idle + 16'd1;
        end
      end
      default: begin
        idle_next  = 16'd0;
        state_next = HDR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= HDR;
      kind    <= 4'd0;
      pc_hold <= 32'd0;
      idle    <= 16'd0;
    end else begin
      state   <= state_next;
      kind    <= kind_next;
      pc_hold <= pc_hold_next;
      idle    <= idle_next;
    end
  end

  // Event pulses and payloads; payloads of a stage hold until that stage emits again.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid <= 1'b0;
      de_valid <= 1'b0;
      ex_valid <= 1'b0;
      wb_valid <= 1'b0;
      if_pc    <= 32'd0;
      de_pc    <= 32'd0;
      de_insn  <= 32'd0;
      ex_pc    <= 32'd0;
      wb_pc    <= 32'd0;
      pkt_err  <= 1'b0;
      seq_err  <= 1'b0;
      evt_cnt  <= 32'd0;
    end else begin
      if_valid <= emit_if;
      de_valid <= emit_de;
      ex_valid <= emit_ex;
      wb_valid <= emit_wb;
      if_pc    <= emit_if ? emit_pc : if_pc;
      de_pc    <= emit_de ? emit_pc : de_pc;
      de_insn  <= emit_de ? emit_insn : de_insn;
      ex_pc    <= emit_ex ? emit_pc : ex_pc;
      wb_pc    <= emit_wb ? emit_pc : wb_pc;
      pkt_err  <= abort;
      seq_err  <= seq_mis;
      evt_cnt  <= evt_cnt + {31'd0, emit_any};
    end
  end

endmodule

// File: tb/tb_microarchtrace_unpacker.sv
// Table-driven bench for microarchtrace_unpacker with a cycle-stamped scoreboard of expected pulses.
module tb_microarchtrace_unpacker;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        if_valid, de_valid, ex_valid, wb_valid;
  logic [31:0] if_pc, de_pc, de_insn, ex_pc, wb_pc;
  logic        pkt_err, seq_err;
  logic [31:0] evt_cnt;

  microarchtrace_unpacker #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .if_valid(if_valid), .if_pc(if_pc),
    .de_valid(de_valid), .de_pc(de_pc), .de_insn(de_insn),
    .ex_valid(ex_valid), .ex_pc(ex_pc),
    .wb_valid(wb_valid), .wb_pc(wb_pc),
    .pkt_err(pkt_err), .seq_err(seq_err), .evt_cnt(evt_cnt)
  );

  always #5 clk = ~clk;

  // pulses bit order: [0] if, [1] de, [2] ex, [3] wb, [4] pkt_err, [5] seq_err
  typedef struct {
    int          due;
    logic [5:0]  pulses;
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] cnt;
  } obs_t;

  typedef struct {
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    int          nw;
    logic [5:0]  exp_pulse;
    logic [31:0] exp_pc;
    logic [31:0] exp_insn;
  } vec_t;

  obs_t        q[$];
  obs_t        mon_o;
  logic [5:0]  mon_p;
  vec_t        vecs[11];
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] m_cnt = 32'd0;
  logic [7:0]  m_seq = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int due, input logic [5:0] p, input logic [31:0] pc, input logic [31:0] insn);
    obs_t o;
    if (|p[3:0]) m_cnt = m_cnt + 32'd1;
    o.due = due; o.pulses = p; o.pc = pc; o.insn = insn; o.cnt = m_cnt;
    q.push_back(o);
  endtask

  task automatic send(input logic [31:0] w);
    s_valid = 1'b1;
    s_data  = w;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_data  = 32'd0;
  endtask

  // Sends a header word and applies the bench's sequence model to it.
  task automatic hdr_word(input logic [31:0] w);
    logic ok;
    send(w);
    ok = (w[31:28] == 4'hA) && (w[3:0] >= 4'd1) && (w[3:0] <= 4'd4);
    if (ok) begin
`ifdef MICROARCHTRACE_UNPACK_SEQ_EN
      if (w[15:8] != m_seq) push(cyc, 6'b100000, 32'd0, 32'd0);
`endif
      m_seq = w[15:8] + 8'd1;
    end
  endtask

  function automatic logic [31:0] mk_hdr(input logic [3:0] t);
    mk_hdr = {4'hA, 12'h000, m_seq, 4'h0, t};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: every negedge either matches the due record or must be quiet.
  always @(negedge clk) begin
    mon_p = {seq_err, pkt_err, wb_valid, ex_valid, de_valid, if_valid};
    if (q.size() > 0 && q[0].due < cyc) begin
      check("missed_pulse_due_cycle", 32'(cyc), 32'(q[0].due));
      void'(q.pop_front());
    end else if (q.size() > 0 && q[0].due == cyc) begin
      mon_o = q.pop_front();
      check("pulses", {26'd0, mon_p}, {26'd0, mon_o.pulses});
      check("evt_cnt", evt_cnt, mon_o.cnt);
      if (mon_o.pulses[0]) check("if_pc", if_pc, mon_o.pc);
      if (mon_o.pulses[1]) check("de_pc", de_pc, mon_o.pc);
      if (mon_o.pulses[1]) check("de_insn", de_insn, mon_o.insn);
      if (mon_o.pulses[2]) check("ex_pc", ex_pc, mon_o.pc);
      if (mon_o.pulses[3]) check("wb_pc", wb_pc, mon_o.pc);
    end else if (mon_p != 6'd0) begin
      check("unexpected_pulse", {26'd0, mon_p}, 32'd0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{32'hA0000001, 32'h00001000, 32'h0, 2, 6'b000001, 32'h00001000, 32'h0};
    vecs[1]  = '{32'hA0000102, 32'h00002000, 32'h00B50513, 3, 6'b000010, 32'h00002000, 32'h00B50513};
    vecs[2]  = '{32'hA0000303, 32'h00003000, 32'h0, 2, 6'b000100, 32'h00003000, 32'h0};
    vecs[3]  = '{32'h50000003, 32'h0, 32'h0, 1, 6'b010000, 32'h0, 32'h0};
    vecs[4]  = '{32'h12345678, 32'h0, 32'h0, 1, 6'b010000, 32'h0, 32'h0};
    vecs[5]  = '{32'hA0000404, 32'h00004000, 32'h0, 2, 6'b001000, 32'h00004000, 32'h0};
    vecs[6]  = '{32'hA0000500, 32'h0, 32'h0, 1, 6'b010000, 32'h0, 32'h0};
    vecs[7]  = '{32'hB0000601, 32'h0, 32'h0, 1, 6'b010000, 32'h0, 32'h0};
    vecs[8]  = '{32'hA0000505, 32'h0, 32'h0, 1, 6'b010000, 32'h0, 32'h0};
    vecs[9]  = '{32'hA0000501, 32'hFFFFFFFC, 32'h0, 2, 6'b000001, 32'hFFFFFFFC, 32'h0};
    vecs[10] = '{32'hA0000602, 32'h00000004, 32'hFFFFFFFF, 3, 6'b000010, 32'h00000004, 32'hFFFFFFFF};

    rst = 1'b1; s_valid = 1'b0; s_data = 32'd0;
    idle(3);
    @(negedge clk);
    check("rst_s_ready", {31'd0, s_ready}, 32'd0);
    check("rst_valids", {26'd0, seq_err, pkt_err, wb_valid, ex_valid, de_valid, if_valid}, 32'd0);
    check("rst_evt_cnt", evt_cnt, 32'd0);
    check("rst_payload_or", if_pc | de_pc | de_insn | ex_pc | wb_pc, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("s_ready_after_rst", {31'd0, s_ready}, 32'd1);
    @(posedge clk); #1;

    // Back-to-back packets straight from the table.
    for (int i = 0; i < 11; i++) begin
      hdr_word(vecs[i].w0);
      if (vecs[i].nw >= 2) send(vecs[i].w1);
      if (vecs[i].nw == 3) send(vecs[i].w2);
      push(cyc, vecs[i].exp_pulse, vecs[i].exp_pc, vecs[i].exp_insn);
    end
    idle(3);

    // Stale WB packet times out, then a complete WB packet still works.
    hdr_word(mk_hdr(4'd4));
    push(cyc + TO, 6'b010000, 32'd0, 32'd0);
    idle(TO + 2);
    hdr_word(mk_hdr(4'd4));
    send(32'h00004444);
    push(cyc, 6'b001000, 32'h00004444, 32'd0);
    idle(2);

    // pc arriving in the very last allowed idle cycle is accepted.
    hdr_word(mk_hdr(4'd1));
    idle(TO - 1);
    send(32'h00005555);
    push(cyc, 6'b000001, 32'h00005555, 32'd0);
    idle(2);

    // Timeout while waiting for the insn word of a DE packet.
    hdr_word(mk_hdr(4'd2));
    send(32'h00006666);
    push(cyc + TO, 6'b010000, 32'd0, 32'd0);
    idle(TO + 2);

    // Counter wrap from all-ones.
    @(negedge clk);
    force dut.evt_cnt = 32'hFFFFFFFF;
    #1;
    release dut.evt_cnt;
    m_cnt = 32'hFFFFFFFF;
    @(posedge clk); #1;
    check("evt_cnt_preload", evt_cnt, 32'hFFFFFFFF);
    hdr_word(mk_hdr(4'd3));
    send(32'h00007777);
    push(cyc, 6'b000100, 32'h00007777, 32'd0);
    idle(2);
    check("evt_cnt_wrapped", evt_cnt, 32'd0);

    // Reset in the middle of a DE packet drops it silently.
    hdr_word(mk_hdr(4'd2));
    send(32'h00008888);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_s_ready", {31'd0, s_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_cnt = 32'd0;
    m_seq = 8'd0;
    idle(2);
    check("mid_rst_evt_cnt", evt_cnt, 32'd0);
    hdr_word(mk_hdr(4'd1));
    send(32'h00009999);
    push(cyc, 6'b000001, 32'h00009999, 32'd0);

    idle(4);
    check("queue_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
